// File: rtl/rns_pkg.sv
// Shared RNS constants and the reconstruction FSM state type.
package rns_pkg;

    // Moduli ordered as in the EX-stage: index 1 is the byte domain, index 0 the odd domain.
    localparam logic [1:0][8:0] RNS_MODULI   = {9'd256, 9'd129};
    localparam logic [8:0]      RNS_MOD_HI   = RNS_MODULI[0];
    localparam logic [7:0]      RNS_INV_HI   = 8'd64;
    localparam int unsigned     RNS_DEST_WID = 4;
    localparam int unsigned     RNS_DATA_WID = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        MUL    = 2'd2,
        DONE   = 2'd3
    } recon_state_e;

endpackage

// File: rtl/mod_dbl_add.sv
// One step of an MSB-first shift-add modular multiply: (2*acc + (add_en ? d : 0)) mod modulus.
module mod_dbl_add (
    input  logic [7:0] acc,
    input  logic [7:0] d,
    input  logic       add_en,
    input  logic [8:0] modulus,
    output logic [7:0] sum_c
);

    logic [9:0] mod_ext;
    logic [9:0] t0;
    logic [9:0] t1;

    // acc < modulus keeps t0 below 3*modulus, so two conditional subtracts suffice.
    always_comb begin
        mod_ext = {1'b0, modulus};
        t0      = {1'b0, acc, 1'b0} + (add_en ? {2'b00, d} : 10'd0);
        t1      = (t0 >= mod_ext) ? t0 - mod_ext : t0;
        sum_c   = (t1 >= mod_ext) ? 8'(t1 - mod_ext) : 8'(t1);
    end

endmodule

// File: rtl/rns_recon_ctrl.sv
// Mixed-radix CRT reconstruction of a (mod 256, mod MOD_HI) RNS value into a 16-bit integer.
// Optional macro RNS_RECON_RANGE_CHK_EN flags a_lo >= MOD_HI as a range error with result 0.
module rns_recon_ctrl
    import rns_pkg::*;
#(
    parameter logic [8:0]  MOD_HI   = RNS_MOD_HI,
    parameter logic [7:0]  INV_HI   = RNS_INV_HI,
    parameter int unsigned DEST_WID = RNS_DEST_WID
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [15:0]         rns_in,
    input  logic [DEST_WID-1:0] dest_in,
    input  logic                flush,
    output logic                busy,
    output logic                done,
    output logic [15:0]         result,
    output logic [DEST_WID-1:0] dest_out,
    output logic                range_err
);

    localparam logic [2:0] MSB_IDX = 3'd7;

    recon_state_e        state_q, state_d;
    logic [7:0]          a_hi_q, a_hi_d;
    logic [7:0]          a_lo_q, a_lo_d;
    logic [DEST_WID-1:0] dest_q, dest_d;
    logic [7:0]          d_q, d_d;
    logic [7:0]          acc_q, acc_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [15:0]         result_q, result_d;
    logic [DEST_WID-1:0] dest_out_q, dest_out_d;
    logic                err_q, err_d;
    logic                range_err_q, range_err_d;

    logic [8:0]          hi_ext;
    logic [8:0]          r_red;
    logic signed [8:0]   diff;
    logic [7:0]          d_calc;
    logic                lo_bad;
    logic [7:0]          mul_sum;

    // a_hi < 2*MOD_HI, so a single conditional subtract reduces it.
    always_comb begin
        hi_ext = {1'b0, a_hi_q};
        r_red  = (hi_ext >= MOD_HI) ? hi_ext - MOD_HI : hi_ext;
        diff   = $signed({1'b0, a_lo_q}) - $signed(r_red);
        d_calc = diff[8] ? 8'(diff + $signed(MOD_HI)) : 8'(diff);
        lo_bad = ({1'b0, a_lo_q} >= MOD_HI);
    end

    mod_dbl_add u_mod_dbl_add (
        .acc     (acc_q),
        .d       (d_q),
        .add_en  (INV_HI[bit_cnt_q]),
        .modulus (MOD_HI),
        .sum_c   (mul_sum)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        a_hi_d      = a_hi_q;
        a_lo_d      = a_lo_q;
        dest_d      = dest_q;
        d_d         = d_q;
        acc_d       = acc_q;
        bit_cnt_d   = bit_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        result_d    = result_q;
        dest_out_d  = dest_out_q;
        err_d       = err_q;
        range_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    a_hi_d  = rns_in[15:8];
                    a_lo_d  = rns_in[7:0];
                    dest_d  = dest_in;
                    busy_d  = 1'b1;
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                if (flush) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    d_d       = d_calc;
                    acc_d     = 8'd0;
                    bit_cnt_d = MSB_IDX;
`ifdef RNS_RECON_RANGE_CHK_EN
                    err_d     = lo_bad;
                    state_d   = lo_bad ? DONE : MUL;
`else
                    err_d     = 1'b0;
                    state_d   = MUL;
`endif
                end
            end
            MUL: begin
                if (flush) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    acc_d     = mul_sum;
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    if (bit_cnt_q == 3'd0) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done_d      = 1'b1;
                busy_d      = 1'b0;
                result_d    = err_q ? 16'h0000 : {acc_q, a_hi_q};
                dest_out_d  = dest_q;
                range_err_d = err_q;
                state_d     = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            a_hi_q      <= 8'd0;
            a_lo_q      <= 8'd0;
            dest_q      <= '0;
            d_q         <= 8'd0;
            acc_q       <= 8'd0;
            bit_cnt_q   <= 3'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= 16'd0;
            dest_out_q  <= '0;
            err_q       <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_hi_q      <= a_hi_d;
            a_lo_q      <= a_lo_d;
            dest_q      <= dest_d;
            d_q         <= d_d;
            acc_q       <= acc_d;
            bit_cnt_q   <= bit_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            dest_out_q  <= dest_out_d;
            err_q       <= err_d;
            range_err_q <= range_err_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign dest_out = dest_out_q;

`ifdef RNS_RECON_RANGE_CHK_EN
    assign range_err = range_err_q;
`else
    // Without the range check the error flag never fires.
    logic unused_err;
    assign unused_err = range_err_q ^ lo_bad;
    assign range_err  = 1'b0;
`endif

endmodule
